// File: rtl/fmdll_pkg.sv
// Shared types and widths for the phase-detector window sequencer.
package fmdll_pkg;

    localparam int M_W    = 2;
    localparam int N_W    = 4;
    localparam int WCNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_COUNT = 2'd2,
        ST_HOLD  = 2'd3
    } seq_state_e;

    // A programmed period of zero behaves as a period of one.
    function automatic logic [N_W-1:0] clamp1(input logic [N_W-1:0] v);
        return (v == '0) ? N_W'(1) : v;
    endfunction

endpackage

// File: rtl/pd_sequencer_if.sv
// Bundle between the sequencer and its environment: window controls, PD counters, result handshake.
interface pd_sequencer_if;
    import fmdll_pkg::*;

    logic           en;
    logic [M_W-1:0] M;
    logic [N_W-1:0] N;
    logic           COMP;
    logic           comp_ready;
    logic [M_W-1:0] M_counter;
    logic [N_W-1:0] N_counter;
    logic           DIV_M;
    logic           Reset_PD;
    logic           comp_valid;
    logic           comp_up;

    modport master (
        output en, M, N, COMP, comp_ready,
        input  M_counter, N_counter, DIV_M, Reset_PD, comp_valid, comp_up
    );

    modport slave (
        input  en, M, N, COMP, comp_ready,
        output M_counter, N_counter, DIV_M, Reset_PD, comp_valid, comp_up
    );

endinterface

// File: rtl/pd_sequencer_mn_counter.sv
// Nested N-inside-M window counters with clear/load/step; end flags decode the current count.
// Single-cycle update; no backpressure, the caller decides when to step.
module mn_counter
    import fmdll_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           clr_i,
    input  logic           load_i,
    input  logic           step_i,
    input  logic [N_W-1:0] meff_i,
    input  logic [N_W-1:0] neff_i,
    output logic [M_W-1:0] m_cnt_o,
    output logic [N_W-1:0] n_cnt_o,
    output logic [M_W-1:0] m_nxt_o,
    output logic [N_W-1:0] n_nxt_o,
    output logic           n_end_o,
    output logic           m_last_o
);

    logic [M_W-1:0] m_q, m_d;
    logic [N_W-1:0] n_q, n_d;

    assign n_end_o  = (n_q == neff_i);
    assign m_last_o = (N_W'(m_q) == meff_i);

    always_comb begin
        m_d = m_q;
        n_d = n_q;
        if (clr_i) begin
            m_d = '0;
            n_d = '0;
        end else if (load_i) begin
            m_d = M_W'(1);
            n_d = N_W'(1);
        end else if (step_i) begin
            if (n_end_o) begin
                n_d = N_W'(1);
                m_d = m_last_o ? M_W'(1) : m_q + 1'b1;
            end else begin
                n_d = n_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            m_q <= '0;
            n_q <= '0;
        end else begin
            m_q <= m_d;
            n_q <= n_d;
        end
    end

    assign m_cnt_o = m_q;
    assign n_cnt_o = n_q;
    assign m_nxt_o = m_d;
    assign n_nxt_o = n_d;

endmodule

// File: rtl/pd_sequencer.sv
// Runs WINDOWS full M*N periods, samples COMP on the final wrap and offers it on comp_valid/comp_ready.
// Result after WINDOWS*Meff*Neff COUNT cycles; HOLD freezes everything until the result is taken.
module pd_sequencer
    import fmdll_pkg::*;
#(
    parameter int WINDOWS = 2
) (
    input  logic          clk_out,
    input  logic          Reset_n,
    pd_sequencer_if.slave bus
);

    localparam logic [WCNT_W-1:0] WLAST = WCNT_W'(WINDOWS - 1);

    seq_state_e     state_q, state_d;
    logic [N_W-1:0] meff_q, meff_d, neff_q, neff_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic           rpd_q, rpd_d, divm_q, divm_d, vld_q, vld_d, up_q, up_d;

    logic           cnt_clr, cnt_load, cnt_step;
    logic [M_W-1:0] m_cnt, m_nxt;
    logic [N_W-1:0] n_cnt, n_nxt;
    logic           n_end, m_last, period_end, final_wrap;

    mn_counter u_mn (
        .clk_i   (clk_out),
        .rst_ni  (Reset_n),
        .clr_i   (cnt_clr),
        .load_i  (cnt_load),
        .step_i  (cnt_step),
        .meff_i  (meff_q),
        .neff_i  (neff_q),
        .m_cnt_o (m_cnt),
        .n_cnt_o (n_cnt),
        .m_nxt_o (m_nxt),
        .n_nxt_o (n_nxt),
        .n_end_o (n_end),
        .m_last_o(m_last)
    );

    assign period_end = n_end && m_last;
    assign final_wrap = (state_q == ST_COUNT) && period_end && (wcnt_q == WLAST);

    always_ff @(posedge clk_out) begin
        if (!Reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (bus.en) state_d = ST_ARM;
            ST_ARM:   state_d = bus.en ? ST_COUNT : ST_IDLE;
            ST_COUNT: begin
                if (!bus.en)        state_d = ST_IDLE;
                else if (final_wrap) state_d = ST_HOLD;
            end
            ST_HOLD:  if (vld_q && bus.comp_ready) state_d = bus.en ? ST_ARM : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Every output is registered, so each one is derived from the state we are entering.
    always_comb begin
        meff_d   = meff_q;
        neff_d   = neff_q;
        wcnt_d   = wcnt_q;
        up_d     = up_q;
        if (state_q == ST_ARM) begin
            meff_d = clamp1(N_W'(bus.M));
            neff_d = clamp1(bus.N);
            wcnt_d = '0;
        end else if (state_q == ST_COUNT && period_end) begin
            wcnt_d = wcnt_q + 1'b1;
        end
        if (state_q == ST_COUNT && state_d == ST_HOLD) up_d = bus.COMP;
        cnt_clr  = (state_d == ST_IDLE);
        cnt_load = (state_d != ST_COUNT) || (state_q != ST_COUNT);
        cnt_step = (state_q == ST_COUNT) && (state_d == ST_COUNT);
        divm_d   = (state_d == ST_COUNT) && (N_W'(m_nxt) == meff_d) && (n_nxt == neff_d);
        rpd_d    = (state_d == ST_IDLE) || (state_d == ST_ARM);
        vld_d    = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk_out) begin
        if (!Reset_n) begin
            meff_q <= N_W'(1);
            neff_q <= N_W'(1);
            wcnt_q <= '0;
            rpd_q  <= 1'b1;
            divm_q <= 1'b0;
            vld_q  <= 1'b0;
            up_q   <= 1'b0;
        end else begin
            meff_q <= meff_d;
            neff_q <= neff_d;
            wcnt_q <= wcnt_d;
            rpd_q  <= rpd_d;
            divm_q <= divm_d;
            vld_q  <= vld_d;
            up_q   <= up_d;
        end
    end

    assign bus.M_counter  = m_cnt;
    assign bus.N_counter  = n_cnt;
    assign bus.DIV_M      = divm_q;
    assign bus.Reset_PD   = rpd_q;
    assign bus.comp_valid = vld_q;
    assign bus.comp_up    = up_q;

endmodule

// File: tb/tb_pd_sequencer.sv
// Directed bench for pd_sequencer: window timing, HOLD backpressure, degenerate sizes, reset and en drop.
module tb_pd_sequencer;
    import fmdll_pkg::*;

    localparam int W = 2;

    logic clk_out = 1'b0;
    logic Reset_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    pd_sequencer_if bus ();

    pd_sequencer #(.WINDOWS(W)) dut (
        .clk_out(clk_out),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    always #5 clk_out = ~clk_out;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_out);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        check_val({tag, "_m"},     bus.M_counter, 0);
        check_val({tag, "_n"},     bus.N_counter, 0);
        check_val({tag, "_rpd"},   bus.Reset_PD, 1);
        check_val({tag, "_div"},   bus.DIV_M, 0);
        check_val({tag, "_valid"}, bus.comp_valid, 0);
    endtask

    task automatic chk_arm(input string tag);
        tick();
        check_val({tag, "_rpd"},   bus.Reset_PD, 1);
        check_val({tag, "_valid"}, bus.comp_valid, 0);
    endtask

    // Steps through ncyc COUNT cycles with an independent counter model.
    task automatic run_count(input int meff, input int neff, input int ncyc,
                             input int chg_at, input logic [1:0] chg_m, input string tag);
        int m = 1;
        int n = 1;
        for (int k = 1; k <= ncyc; k++) begin
            tick();
            check_val({tag, "_m"},     bus.M_counter, m);
            check_val({tag, "_n"},     bus.N_counter, n);
            check_val({tag, "_div"},   bus.DIV_M, (m == meff && n == neff) ? 1 : 0);
            check_val({tag, "_rpd"},   bus.Reset_PD, 0);
            check_val({tag, "_valid"}, bus.comp_valid, 0);
            if (k == chg_at) bus.M = chg_m;
            if (n == neff) begin
                n = 1;
                m = (m == meff) ? 1 : m + 1;
            end else begin
                n++;
            end
        end
    endtask

    task automatic chk_hold(input string tag, input logic up);
        tick();
        check_val({tag, "_valid"}, bus.comp_valid, 1);
        check_val({tag, "_up"},    bus.comp_up, up);
        check_val({tag, "_m"},     bus.M_counter, 1);
        check_val({tag, "_n"},     bus.N_counter, 1);
        check_val({tag, "_rpd"},   bus.Reset_PD, 0);
        check_val({tag, "_div"},   bus.DIV_M, 0);
    endtask

    initial begin
        bus.en = 1'b0; bus.M = 2'd2; bus.N = 4'd4;
        bus.COMP = 1'b1; bus.comp_ready = 1'b1;
        Reset_n = 1'b0;
        tick(); tick();
        chk_idle("rst");
        check_val("rst_up", bus.comp_up, 0);
        Reset_n = 1'b1;
        tick();
        chk_idle("idle_en0");

        // M=2 N=4 COMP=1, ready high: 16 COUNT cycles, 1 HOLD, then ARM again.
        bus.en = 1'b1;
        chk_arm("t1_arm");
        run_count(2, 4, 16, 0, 2'd0, "t1");
        chk_hold("t1_hold", 1'b1);
        chk_arm("t1_rearm");

        // COMP=0 with ready low for 5 cycles in HOLD.
        bus.COMP = 1'b0; bus.comp_ready = 1'b0;
        run_count(2, 4, 16, 0, 2'd0, "t2");
        chk_hold("t2_hold", 1'b0);
        for (int i = 0; i < 5; i++) chk_hold("t2_stall", 1'b0);
        bus.comp_ready = 1'b1;
        chk_arm("t2_rearm");

        // M=0 N=0 behave as 1/1.
        bus.M = 2'd0; bus.N = 4'd0;
        run_count(1, 1, 2, 0, 2'd0, "t3");
        chk_hold("t3_hold", 1'b0);
        chk_arm("t3_rearm");

        // M changes 2->3 mid-run; only the next ARM picks it up.
        bus.M = 2'd2; bus.N = 4'd2; bus.COMP = 1'b1;
        run_count(2, 2, 8, 3, 2'd3, "t4a");
        chk_hold("t4a_hold", 1'b1);
        chk_arm("t4_rearm");
        run_count(3, 2, 12, 0, 2'd0, "t4b");
        chk_hold("t4b_hold", 1'b1);
        chk_arm("t4b_rearm");

        // Reset mid-window, then full latency after restart.
        bus.M = 2'd2; bus.N = 4'd4;
        run_count(2, 4, 3, 0, 2'd0, "t5a");
        Reset_n = 1'b0;
        tick();
        chk_idle("t5_rst_win");
        check_val("t5_rst_win_up", bus.comp_up, 0);
        Reset_n = 1'b1;
        chk_arm("t5_arm");
        run_count(2, 4, 16, 0, 2'd0, "t5b");
        chk_hold("t5b_hold", 1'b1);
        bus.comp_ready = 1'b0;
        Reset_n = 1'b0;
        tick();
        chk_idle("t5_rst_hold");
        check_val("t5_rst_hold_up", bus.comp_up, 0);
        Reset_n = 1'b1; bus.comp_ready = 1'b1;
        chk_arm("t5_arm2");
        run_count(2, 4, 16, 0, 2'd0, "t5c");
        chk_hold("t5c_hold", 1'b1);
        chk_arm("t5c_rearm");

        // en dropped at COUNT cycle 5 with M=3 N=15: no result.
        bus.M = 2'd3; bus.N = 4'd15;
        run_count(3, 15, 5, 0, 2'd0, "t6");
        bus.en = 1'b0;
        tick();
        chk_idle("t6_drop");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle("t6_idle");
        end

        // en dropped during HOLD: handshake first, then IDLE.
        bus.M = 2'd1; bus.N = 4'd2; bus.en = 1'b1;
        chk_arm("t7_arm");
        run_count(1, 2, 4, 0, 2'd0, "t7");
        chk_hold("t7_hold", 1'b1);
        bus.en = 1'b0; bus.comp_ready = 1'b0;
        chk_hold("t7_hold_en0", 1'b1);
        bus.comp_ready = 1'b1;
        tick();
        chk_idle("t7_done");
        tick();
        chk_idle("t7_stay");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
